// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: FIFO-buffered UART transmitter with configurable data width, parity and stop bits
module uart_tx_buffered #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [DATA_BITS-1:0]                 tx_data,
  input  logic                                 tx_request,
  output logic                                 tx_full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      tx_count,
  output logic                                 tx_busy,
  output logic                                 tx_dropped,
  output logic                                 tx_line
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(DATA_BITS);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  state_t               r_state;
  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wptr, r_rptr;
  logic [CW-1:0]        r_count;
  logic                 r_full, r_dropped, r_line, r_par, r_stop_idx;
  logic [BW-1:0]        r_baud;
  logic [IW-1:0]        r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 w_push, w_pop, w_tick, w_last_stop;
  logic [CW-1:0]        w_count_nxt;
  logic [DATA_BITS-1:0] w_head;
  // full is the registered flag, so a push at full is refused even if a pop happens on the same edge
  assign w_push      = tx_request & ~r_full;
  assign w_tick      = r_baud == '0;
  assign w_last_stop = r_state == STOP && w_tick && r_stop_idx == 1'(STOP_BITS - 1);
  assign w_pop       = (r_state == IDLE || w_last_stop) && r_count != '0;
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
  assign w_head      = r_mem[r_rptr];
  always_ff @(posedge clk)
    if (w_push && !reset) r_mem[r_wptr] <= tx_data;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_full    <= 1'b0;
      r_dropped <= 1'b0;
    end else begin
      r_wptr    <= r_wptr + AW'(w_push);
      r_rptr    <= r_rptr + AW'(w_pop);
      r_count   <= w_count_nxt;
      r_full    <= w_count_nxt == CW'(FIFO_DEPTH);
      r_dropped <= tx_request & r_full;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_line     <= 1'b1;
      r_baud     <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_shift    <= '0;
      r_par      <= 1'b0;
    end else begin
      r_baud <= w_tick ? BW'(CLKS_PER_BIT - 1) : r_baud - 1'b1;
      if (w_pop) begin
        r_state <= START;
        r_line  <= 1'b0;
        r_shift <= w_head;
        r_par   <= (PARITY == 2) ^ (^w_head);
        r_baud  <= BW'(CLKS_PER_BIT - 1);
      end else if (w_tick) begin
        case (r_state)
          START: begin
            r_state   <= DATA;
            r_line    <= r_shift[0];
            r_shift   <= r_shift >> 1;
            r_bit_idx <= '0;
          end
          DATA: begin
            if (r_bit_idx == IW'(DATA_BITS - 1)) begin
              r_state    <= PARITY != 0 ? PAR : STOP;
              r_line     <= PARITY != 0 ? r_par : 1'b1;
              r_stop_idx <= 1'b0;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
              r_line    <= r_shift[0];
              r_shift   <= r_shift >> 1;
            end
          end
          PAR: begin
            r_state    <= STOP;
            r_line     <= 1'b1;
            r_stop_idx <= 1'b0;
          end
          STOP: begin
            r_state    <= w_last_stop ? IDLE : STOP;
            r_line     <= 1'b1;
            r_stop_idx <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
  assign tx_line    = r_line;
  assign tx_full    = r_full;
  assign tx_count   = r_count;
  assign tx_busy    = r_state != IDLE;
  assign tx_dropped = r_dropped;
endmodule
